data_mem_slave: RTL and testbench

DATA_MEM_SLAVE -- requirements
Module: data_mem_slave

---
 rtl/data_mem_slave_pkg.sv | 18 +
 rtl/data_mem_slave_amo_alu.sv | 35 +++
 rtl/data_mem_slave.sv | 111 +++++++++++
 tb/tb_data_mem_slave.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_slave_pkg.sv
// data_mem_slave_pkg: package pipeline holding XLEN, the AMO funct5 encodings and the FSM states.
package pipeline;
  localparam int XLEN = 64;
  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_op_e;
  typedef enum logic [1:0] {IDLE, READ, AMO_WR, ACK} state_e;
endpackage

// File: rtl/data_mem_slave_amo_alu.sv
// amo_alu: combinational AMO datapath; in 32-bit mode only new_o[31:0] is meaningful.
module amo_alu
  import pipeline::*;
(
  input  amo_op_e          op_i,
  input  logic [XLEN-1:0]  old_i,
  input  logic [XLEN-1:0]  operand_i,
  input  logic             w32_i,
  output logic [XLEN-1:0]  new_o
);
  logic [XLEN-1:0] a_s, b_s, a_u, b_u;
  logic lt_s, lt_u;
  // 32-bit ops are widened so one signed and one unsigned comparator serve both widths
  assign a_s = w32_i ? {{XLEN-32{old_i[31]}}, old_i[31:0]} : old_i;
  assign b_s = w32_i ? {{XLEN-32{operand_i[31]}}, operand_i[31:0]} : operand_i;
  assign a_u = w32_i ? {{XLEN-32{1'b0}}, old_i[31:0]} : old_i;
  assign b_u = w32_i ? {{XLEN-32{1'b0}}, operand_i[31:0]} : operand_i;
  assign lt_s = $signed(a_s) < $signed(b_s);
  assign lt_u = a_u < b_u;
  always_comb begin
    new_o = old_i;
    case (op_i)
      AMO_ADD:          new_o = a_s + b_s;
      AMO_SWAP, AMO_SC: new_o = b_s;
      AMO_XOR:          new_o = a_s ^ b_s;
      AMO_AND:          new_o = a_s & b_s;
      AMO_OR:           new_o = a_s | b_s;
      AMO_MIN:          new_o = lt_s ? a_s : b_s;
      AMO_MAX:          new_o = lt_s ? b_s : a_s;
      AMO_MINU:         new_o = lt_u ? a_u : b_u;
      AMO_MAXU:         new_o = lt_u ? b_u : a_u;
      default:          new_o = old_i;
    endcase
  end
endmodule

// File: rtl/data_mem_slave.sv
// data_mem_slave: word-addressed data memory with registered read and RISC-V AMOs.
// LR/SC reservation tracking is enabled by defining DATA_MEM_LRSC_EN.
module data_mem_slave
  import pipeline::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_re,
  input  logic              data_we,
  input  logic              atomic,
  input  logic [4:0]        amo_op,
  input  logic [XLEN/8-1:0] data_sel,
  input  logic [XLEN-1:0]   data_addr,
  input  logic [XLEN-1:0]   data_w,
  output logic              data_ack,
  output logic [XLEN-1:0]   data_r
);
  localparam int IW = $clog2(DEPTH);
  localparam int OW = $clog2(XLEN/8);
  localparam logic [XLEN/8-1:0] SEL_LO = {{XLEN/8-4{1'b0}}, 4'hF};
  localparam logic [XLEN/8-1:0] SEL_HI = SEL_LO << 4;
  state_e state_q, state_d;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rd_q, res_q, res_d, alu_new, wr_data, lane_old, lane_opd, ret;
  logic [XLEN/8-1:0] wr_be;
  logic [IW-1:0] idx;
  logic req, w32, hi, known, sc_ok, sc_ok_q, sc_ok_d, wr_en, unused_addr;
  amo_op_e op;
  assign op = amo_op_e'(amo_op);
  assign idx = data_addr[OW +: IW];
  assign unused_addr = ^{data_addr[XLEN-1:OW+IW], data_addr[OW-1:0]};
  assign req = data_re | data_we;
  assign hi = data_sel == SEL_HI;
  assign w32 = hi || data_sel == SEL_LO;
  assign lane_old = hi ? rd_q >> 32 : rd_q;
  assign lane_opd = hi ? data_w >> 32 : data_w;
  assign ret = w32 ? {{XLEN-32{lane_old[31]}}, lane_old[31:0]} : rd_q;
  assign known = op inside {AMO_ADD, AMO_SWAP, AMO_XOR, AMO_AND, AMO_OR,
                            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU};
  amo_alu u_alu (
    .op_i      (op),
    .old_i     (lane_old),
    .operand_i (lane_opd),
    .w32_i     (w32),
    .new_o     (alu_new)
  );
`ifdef DATA_MEM_LRSC_EN
  logic resv_v_q;
  logic [IW-1:0] resv_idx_q;
  assign sc_ok = resv_v_q && resv_idx_q == idx;
  always_ff @(posedge clk) begin
    if (reset) resv_v_q <= 1'b0;
    else if (state_q == READ && atomic && (op == AMO_LR || op == AMO_SC)) begin
      resv_v_q   <= op == AMO_LR;
      resv_idx_q <= idx;
    end else if (wr_en && idx == resv_idx_q) resv_v_q <= 1'b0;
  end
`else
  assign sc_ok = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    sc_ok_d = sc_ok_q;
    wr_en   = 1'b0;
    wr_be   = data_sel;
    wr_data = data_w;
    case (state_q)
      IDLE: if (req) begin
        state_d = (data_we && !atomic) ? ACK : READ;
        wr_en   = data_we && !atomic;
        res_d   = '0;
      end
      READ: begin
        state_d = atomic ? AMO_WR : ACK;
        res_d   = !atomic ? rd_q : op == AMO_SC ? XLEN'(!sc_ok) : ret;
        sc_ok_d = sc_ok;
      end
      AMO_WR: begin
        state_d = ACK;
        wr_en   = known || (op == AMO_SC && sc_ok_q);
        wr_be   = w32 ? data_sel : '1;
        wr_data = w32 ? {XLEN/32{alu_new[31:0]}} : alu_new;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) wr_en = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      sc_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      sc_ok_q <= sc_ok_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < XLEN/8; b++)
        if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
    rd_q <= mem_q[idx];
  end
  assign data_ack = state_q == ACK && !reset;
  assign data_r = data_ack ? res_q : '0;
endmodule

// File: tb/tb_data_mem_slave.sv
// tb_data_mem_slave: directed plus randomized checks of data_mem_slave against a word-array model.
module tb_data_mem_slave;
  logic clk, reset, data_re, data_we, atomic, data_ack;
  logic [4:0] amo_op;
  logic [7:0] data_sel;
  logic [63:0] data_addr, data_w, data_r, r;
  int checks = 0, errors = 0;
  logic [63:0] mm [1024];
  bit rv = 0;
  int ridx = -1;

  data_mem_slave #(.DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .data_re(data_re), .data_we(data_we), .atomic(atomic),
    .amo_op(amo_op), .data_sel(data_sel), .data_addr(data_addr), .data_w(data_w),
    .data_ack(data_ack), .data_r(data_r)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] f64(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    longint sa = a, sb = b;
    case (op)
      5'h00: return {1'b1, a + b};
      5'h01: return {1'b1, b};
      5'h04: return {1'b1, a ^ b};
      5'h0C: return {1'b1, a & b};
      5'h08: return {1'b1, a | b};
      5'h10: return {1'b1, sa < sb ? a : b};
      5'h14: return {1'b1, sa > sb ? a : b};
      5'h18: return {1'b1, a < b ? a : b};
      5'h1C: return {1'b1, a > b ? a : b};
      default: return {1'b0, a};
    endcase
  endfunction

  function automatic logic [32:0] f32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa = a, sb = b;
    case (op)
      5'h00: return {1'b1, a + b};
      5'h01: return {1'b1, b};
      5'h04: return {1'b1, a ^ b};
      5'h0C: return {1'b1, a & b};
      5'h08: return {1'b1, a | b};
      5'h10: return {1'b1, sa < sb ? a : b};
      5'h14: return {1'b1, sa > sb ? a : b};
      5'h18: return {1'b1, a < b ? a : b};
      5'h1C: return {1'b1, a > b ? a : b};
      default: return {1'b0, a};
    endcase
  endfunction

  // Applies one request to the model memory and returns the expected data_r.
  function automatic logic [63:0] model(input logic we, input logic at, input logic [4:0] op,
                                        input logic [7:0] sel, input logic [63:0] addr, input logic [63:0] wd);
    int idx = int'(addr[12:3]);
    logic [63:0] old = mm[idx], nv = mm[idx], ret;
    logic [32:0] r32;
    logic [64:0] r64;
    logic [31:0] o32, d32;
    logic w32, hi, wr = 0;
    logic [4:0] eop = op;
    if (we && !at) begin
      for (int b = 0; b < 8; b++) if (sel[b]) nv[8*b +: 8] = wd[8*b +: 8];
      mm[idx] = nv;
      if (idx == ridx) rv = 0;
      return '0;
    end
    if (!at) return old;
    if (op == 5'b00011) begin
`ifdef DATA_MEM_LRSC_EN
      wr = rv && ridx == idx;
`else
      wr = 0;
`endif
      rv = 0;
      eop = wr ? 5'b00001 : 5'b11111;
    end
`ifdef DATA_MEM_LRSC_EN
    if (op == 5'b00010) begin rv = 1; ridx = idx; end
`endif
    hi = sel == 8'hF0;
    w32 = hi || sel == 8'h0F;
    if (w32) begin
      o32 = hi ? old[63:32] : old[31:0];
      d32 = hi ? wd[63:32] : wd[31:0];
      r32 = f32(eop, o32, d32);
      ret = {{32{o32[31]}}, o32};
      nv = hi ? {r32[31:0], old[31:0]} : {old[63:32], r32[31:0]};
      wr = r32[32];
    end else begin
      r64 = f64(eop, old, wd);
      ret = old;
      nv = r64[63:0];
      wr = r64[64];
    end
    if (op == 5'b00011) ret = {63'b0, !wr};
    if (wr) begin
      mm[idx] = nv;
      if (idx == ridx) rv = 0;
    end
    return ret;
  endfunction

  task automatic xact(input logic re, input logic we, input logic at, input logic [4:0] op,
                      input logic [7:0] sel, input logic [63:0] addr, input logic [63:0] wd,
                      output logic [63:0] rd);
    logic [63:0] exp;
    int lat = 0, want;
    want = (we && !at) ? 1 : at ? 3 : 2;
    exp = model(we, at, op, sel, addr, wd);
    @(negedge clk);
    data_re = re; data_we = we; atomic = at; amo_op = op;
    data_sel = sel; data_addr = addr; data_w = wd;
    do begin
      @(posedge clk); #1; lat++;
    end while (!data_ack && lat < 8);
    chk("latency", 64'(lat), 64'(want));
    if (!(we && !at)) chk("data_r", data_r, exp);
    rd = data_r;
    @(negedge clk);
    data_re = 0; data_we = 0; atomic = 0;
    @(posedge clk); #1;
    chk("ack_pulse", 64'(data_ack), 64'd0);
    chk("r_idle", data_r, 64'd0);
  endtask

  initial begin
    logic [4:0] ops [12] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08, 5'h0C,
                             5'h10, 5'h14, 5'h18, 5'h1C, 5'h05};
    logic [7:0] sels [3] = '{8'hFF, 8'h0F, 8'hF0};
    logic [63:0] a;
    int acks;
    reset = 1; data_re = 0; data_we = 0; atomic = 0; amo_op = 0;
    data_sel = 0; data_addr = 0; data_w = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(data_ack), 64'd0);
    chk("rst_r", data_r, 64'd0);
    @(negedge clk) reset = 0;
    // write then read with data_re also high on the write
    xact(1, 1, 0, 0, 8'hFF, 64'h40, 64'hDEADBEEF_CAFEF00D, r);
    xact(1, 0, 0, 0, 8'hFF, 64'h40, 64'h0, r);
    chk("rd_40", r, 64'hDEADBEEF_CAFEF00D);
    // 32-bit AMOADD on lower lane
    xact(0, 1, 0, 0, 8'hFF, 64'h08, 64'd5, r);
    xact(0, 1, 1, 5'h00, 8'h0F, 64'h08, 64'hFFFFFFFF, r);
    chk("amoadd_ret", r, 64'd5);
    xact(1, 0, 0, 0, 8'hFF, 64'h08, 64'h0, r);
    chk("amoadd_mem", r, 64'd4);
    // MINU vs MIN on full width
    xact(0, 1, 0, 0, 8'hFF, 64'h20, 64'hFFFFFFFF_FFFFFFFE, r);
    xact(0, 1, 1, 5'h18, 8'hFF, 64'h20, 64'd3, r);
    chk("minu_ret", r, 64'hFFFFFFFF_FFFFFFFE);
    xact(1, 0, 0, 0, 8'hFF, 64'h20, 64'h0, r);
    chk("minu_mem", r, 64'd3);
    xact(0, 1, 0, 0, 8'hFF, 64'h20, 64'hFFFFFFFF_FFFFFFFE, r);
    xact(0, 1, 1, 5'h10, 8'hFF, 64'h20, 64'd3, r);
    xact(1, 0, 0, 0, 8'hFF, 64'h20, 64'h0, r);
    chk("min_mem", r, 64'hFFFFFFFF_FFFFFFFE);
    // upper lane AMOMAX sign-extends the returned old value
    xact(0, 1, 0, 0, 8'hFF, 64'h28, 64'h80000000_00000011, r);
    xact(0, 1, 1, 5'h14, 8'hF0, 64'h28, 64'h00000007_00000000, r);
    chk("max_hi_ret", r, 64'hFFFFFFFF_80000000);
    xact(1, 0, 0, 0, 8'hFF, 64'h28, 64'h0, r);
    chk("max_hi_mem", r, 64'h00000007_00000011);
    // LR/SC
    xact(0, 1, 0, 0, 8'hFF, 64'h100, 64'hAB, r);
`ifdef DATA_MEM_LRSC_EN
    xact(1, 0, 1, 5'h02, 8'hFF, 64'h100, 64'h0, r);
    xact(0, 1, 1, 5'h03, 8'hFF, 64'h100, 64'd7, r);
    chk("sc_ok", r, 64'd0);
    xact(0, 1, 1, 5'h03, 8'hFF, 64'h100, 64'd9, r);
    chk("sc_again", r, 64'd1);
    xact(1, 0, 0, 0, 8'hFF, 64'h100, 64'h0, r);
    chk("sc_mem", r, 64'd7);
    xact(1, 0, 1, 5'h02, 8'hFF, 64'h100, 64'h0, r);
    xact(0, 1, 0, 0, 8'hFF, 64'h100, 64'h55, r);
    xact(0, 1, 1, 5'h03, 8'hFF, 64'h100, 64'd8, r);
    chk("sc_broken", r, 64'd1);
    xact(1, 0, 0, 0, 8'hFF, 64'h100, 64'h0, r);
    chk("sc_broken_mem", r, 64'h55);
`else
    xact(1, 0, 1, 5'h02, 8'hFF, 64'h100, 64'h0, r);
    chk("lr_read", r, 64'hAB);
    xact(0, 1, 1, 5'h03, 8'hFF, 64'h100, 64'd7, r);
    chk("sc_fail", r, 64'd1);
    xact(1, 0, 0, 0, 8'hFF, 64'h100, 64'h0, r);
    chk("sc_mem", r, 64'hAB);
`endif
    // reset during AMO_WR of a SWAP
    xact(0, 1, 0, 0, 8'hFF, 64'h80, 64'h1111, r);
    @(negedge clk);
    data_we = 1; atomic = 1; amo_op = 5'h01; data_sel = 8'hFF; data_addr = 64'h80; data_w = 64'h2222;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    #1 chk("rst_amo_ack", 64'(data_ack), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 0; data_we = 0; atomic = 0;
    rv = 0;
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      acks += int'(data_ack);
    end
    chk("rst_no_ack", 64'(acks), 64'd0);
    xact(1, 0, 0, 0, 8'hFF, 64'h80, 64'h0, r);
    chk("rst_mem", r, 64'h1111);
    // address wrap
    xact(0, 1, 0, 0, 8'hFF, 64'(1024 * 8 + 16), 64'h0123_4567_89AB_CDEF, r);
    xact(1, 0, 0, 0, 8'hFF, 64'h10, 64'h0, r);
    chk("wrap", r, 64'h0123_4567_89AB_CDEF);
    // randomized traffic over a small pool of words
    for (int k = 0; k < 8; k++)
      xact(0, 1, 0, 0, 8'hFF, 64'((48 + k) * 8), {$urandom, $urandom}, r);
    for (int i = 0; i < 80; i++) begin
      a = (64'($urandom) << 13) | (64'(48 + $urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: xact($urandom_range(0, 1), 1, 0, 0, 8'($urandom_range(1, 255)), a, {$urandom, $urandom}, r);
        1: xact(1, 0, 0, 0, 8'hFF, a, 64'h0, r);
        default: xact($urandom_range(0, 1), 1, 1, ops[$urandom_range(0, 11)],
                      sels[$urandom_range(0, 2)], a, {$urandom, $urandom}, r);
      endcase
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
